// File: rtl/gray_cell_impar.sv
//------------------------------------------------------------------------------
// gray_cell_impar : Brent-Kung odd-node gray cell, Go = Gi | (Pi & Gk) per lane
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_cell_impar #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Gi,
  input  logic [WIDTH-1:0] Pi,
  input  logic [WIDTH-1:0] Gk,
  output logic [WIDTH-1:0] Go_comb,
  output logic [WIDTH-1:0] Go,
  output logic             out_valid
);

  // Lanes never interact; propagate is consumed here and not forwarded.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign Go_comb[i] = Gi[i] | (Pi[i] & Gk[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Go        <= RESET_VAL;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Go <= Go_comb;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_cell_impar.sv
//------------------------------------------------------------------------------
// tb_gray_cell_impar : directed self-checking bench for gray_cell_impar
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_cell_impar;

  logic       clk = 1'b0;
  logic       rst;
  logic       v1, v4;
  logic [0:0] gi1, pi1, gk1;
  logic [0:0] gc1, go1;
  logic       ov1;
  logic [3:0] gi4, pi4, gk4;
  logic [3:0] gc4, go4;
  logic       ov4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray_cell_impar #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1),
    .Gi(gi1), .Pi(pi1), .Gk(gk1),
    .Go_comb(gc1), .Go(go1), .out_valid(ov1)
  );

  gray_cell_impar #(.WIDTH(4), .RESET_VAL(4'b0110)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4),
    .Gi(gi4), .Pi(pi4), .Gk(gk4),
    .Go_comb(gc4), .Go(go4), .out_valid(ov4)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic [2:0] gpk);
    gi1 = gpk[2];
    pi1 = gpk[1];
    gk1 = gpk[0];
  endtask

  initial begin
    logic [7:0] truth;
    logic       exp_bit;
    truth = 8'b1111_1000;  // index = {Gi,Pi,Gk}

    rst = 1'b1; v1 = 1'b0; v4 = 1'b0;
    set1(3'b000);
    gi4 = '0; pi4 = '0; gk4 = '0;
    tick(); tick();
    chk("reset_go_w1", {3'b0, go1}, 4'd0);
    chk("reset_ov_w1", {3'b0, ov1}, 4'd0);
    chk("reset_go_w4", go4, 4'b0110);
    chk("reset_ov_w4", {3'b0, ov4}, 4'd0);

    // Exhaustive truth table, registered copy one edge later
    rst = 1'b0; v1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set1(k[2:0]);
      exp_bit = truth[k];
      #1;
      chk($sformatf("tt_comb_%0d", k), {3'b0, gc1}, {3'b0, exp_bit});
      tick();
      chk($sformatf("tt_reg_%0d", k), {3'b0, go1}, {3'b0, exp_bit});
      chk($sformatf("tt_ov_%0d", k), {3'b0, ov1}, 4'd1);
    end

    // Reset with Gi=1: comb unaffected, register cleared
    rst = 1'b1; v1 = 1'b0; set1(3'b100);
    #1;
    chk("rst_comb_before", {3'b0, gc1}, 4'd1);
    tick();
    chk("rst_go", {3'b0, go1}, 4'd0);
    chk("rst_ov", {3'b0, ov1}, 4'd0);
    chk("rst_comb_during", {3'b0, gc1}, 4'd1);
    rst = 1'b0;

    // Hold
    v1 = 1'b1; set1(3'b100);
    tick();
    chk("hold_load_go", {3'b0, go1}, 4'd1);
    chk("hold_load_ov", {3'b0, ov1}, 4'd1);
    v1 = 1'b0; set1(3'b000);
    #1;
    chk("hold_comb", {3'b0, gc1}, 4'd0);
    tick();
    chk("hold_go", {3'b0, go1}, 4'd1);
    chk("hold_ov", {3'b0, ov1}, 4'd0);
    tick();
    chk("hold_go_2", {3'b0, go1}, 4'd1);

    // Lane independence
    v4 = 1'b1; gi4 = 4'b0001; pi4 = 4'b1010; gk4 = 4'b1000;
    #1;
    chk("lane_comb", gc4, 4'b1001);
    tick();
    chk("lane_go", go4, 4'b1001);
    chk("lane_ov", {3'b0, ov4}, 4'd1);
    gi4 = 4'b0100; pi4 = 4'b0011; gk4 = 4'b0110;
    #1;
    chk("lane_comb_2", gc4, 4'b0110);
    tick();
    chk("lane_go_2", go4, 4'b0110);
    v4 = 1'b0;

    // Streaming alternating 011 / 010
    v1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set1((k % 2 == 0) ? 3'b011 : 3'b010);
      tick();
      chk($sformatf("stream_go_%0d", k), {3'b0, go1}, (k % 2 == 0) ? 4'd1 : 4'd0);
      chk($sformatf("stream_ov_%0d", k), {3'b0, ov1}, 4'd1);
    end

    // Reset beats valid on the same edge
    rst = 1'b1; v1 = 1'b1; set1(3'b111);
    v4 = 1'b1; gi4 = 4'b1111; pi4 = 4'b1111; gk4 = 4'b1111;
    tick();
    chk("prio_go_w1", {3'b0, go1}, 4'd0);
    chk("prio_ov_w1", {3'b0, ov1}, 4'd0);
    chk("prio_go_w4", go4, 4'b0110);
    chk("prio_ov_w4", {3'b0, ov4}, 4'd0);

    // First valid after reset lands one edge later
    rst = 1'b0; set1(3'b100);
    tick();
    chk("post_rst_go", {3'b0, go1}, 4'd1);
    chk("post_rst_ov", {3'b0, ov1}, 4'd1);
    chk("post_rst_go_w4", go4, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1);
  end

endmodule

`default_nettype wire
